pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central sequencer for the five-stage RV32I pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates every stage's en/flush and the PC load enable from three sources: instruction/data cache handshakes, load-use hazards, and control-flow redirects.
- Owns per-port handshake state so a cache response that arrives while the pipeline is frozen by the other port is captured once, never re-requested.
- Keeps hazard-event performance counters.

Parameters:
CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
imem_resp  in  1  I-cache response pulse, rdata valid this cycle
imem_read  out  1  I-cache read request, held until imem_resp
imem_latch  out  1  datapath captures imem_rdata into holding register
imem_sel_hold  out  1  IF/ID input takes holding register instead of live imem_rdata
dmem_req  in  1  instruction in MEM needs data access (load or store)
dmem_resp  in  1  D-cache response pulse
dmem_go  out  1  gates dmem_read/dmem_write to the cache
dmem_latch  out  1  capture dmem_rdata into holding register
dmem_sel_hold  out  1  MEM/WB input takes holding register
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  5  destination of instruction in EX
ifid_rs1, ifid_rs2  in  5 each  sources of instruction in ID
ifid_use_rs1, ifid_use_rs2  in  1 each  ID instruction actually reads that source
ex_redirect  in  1  taken branch/jal/jalr resolved in EX; PC mux already selects target
pc_en  out  1  PC register load
ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en  out  1 each  pipeline register controls
stall_cycles, loaduse_count, redirect_count  out  CNT_W each  performance counters

Behaviour:
- Flush semantics: flush loads a NOP bubble; it is only meaningful with en=1. This block never asserts flush with en=0.
- I-port FSM, states I_REQ and I_HOLD:
  - imem_read=(state==I_REQ)
  - I_REQ -> I_HOLD when imem_resp & dmem_busy
  - I_HOLD -> I_REQ when ~stall
  - imem_latch = imem_resp & state==I_REQ
  - imem_sel_hold = state==I_HOLD
- D-port FSM, states D_REQ and D_DONE:
  - dmem_go = dmem_req & state==D_REQ
  - D_REQ -> D_DONE when dmem_go & dmem_resp & imem_busy
  - D_DONE -> D_REQ when ~stall
  - dmem_latch = dmem_go & dmem_resp
  - dmem_sel_hold = state==D_DONE
- Busy and stall terms:
  - imem_busy = I_REQ & ~imem_resp
  - dmem_busy = dmem_go & ~dmem_resp
  - stall = imem_busy | dmem_busy
- Priority per cycle (combinational; outputs not listed in a case are 0):
  1. stall: all en=0, all flush=0.
  2. ex_redirect: all en=1, ifid_flush=1, idex_flush=1. The instruction in ID is killed, so no load-use check applies.
  3. load-use: idex_mem_read & idex_rd!=0 & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)). Then pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. Exactly one bubble; on the next cycle the load is in MEM and the hazard term drops.
  4. otherwise: all en=1, flush=0.
- Simultaneous responses: imem_resp and dmem_resp in the same cycle mean stall=0 and the pipeline advances. Neither FSM leaves its REQ state.
- Response while the other port is busy: the FSM enters its hold/done state, the data is latched, and the same request is not reissued. The next cycle's request is issued only after the pipeline advances.
- Redirect while stalled: it is deferred, because the EX instruction is held. It is applied in the first non-stall cycle. A word held in I_HOLD is discarded by ifid_flush.
- Counters, each saturating-free and wrapping:
  - stall_cycles increments on stall.
  - loaduse_count increments on a priority-3 cycle.
  - redirect_count increments on a priority-2 cycle.
- Reset (rst=0, asynchronous):
  - FSMs go to I_REQ and D_REQ; counters go to 0.
  - While in reset, all en, flush, imem_read, dmem_go, latch and sel outputs are forced to 0.
  - The first cycle after release has imem_read=1.
  - Reset mid-request abandons the request; the caches tolerate this.

Decomposition:
- A shared package holds the FSM state enums (istate_t, dstate_t) and a stage_ctrl_t struct bundling the en/flush outputs.
- One sub-module, mem_port_tracker, is instantiated twice (I and D). It takes req, resp and other_busy, and produces go, latch, sel_hold and busy.
- The hazard/priority logic and the counters live in the top module.

Test Plan:
- Reset then release; imem_resp on cycle 3 -> imem_read=1 in cycles 1-3, all en=1 in cycle 3, stall_cycles=2.
- ID reads x5, EX is a load to x5 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle, loaduse_count=1. Same case with idex_rd=0 -> no stall.
- dmem_req=1; dmem_resp at cycle 2 while imem pending until cycle 5 -> dmem_latch pulse at cycle 2, dmem_sel_hold=1 and dmem_go=0 for cycles 3-5, pipeline advances at cycle 5, D FSM back to D_REQ at cycle 6.
- ex_redirect during an I-cache miss (resp at cycle 4) -> no flush in cycles 1-3; cycle 4 has ifid_flush=1, idex_flush=1, all en=1, redirect_count=1.
- ex_redirect and load-use asserted together with no stall -> redirect wins, loaduse_count unchanged.
- rst driven low mid-D_DONE -> outputs go to 0 immediately; after release, FSMs are in I_REQ/D_REQ and counters read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic {
    I_REQ  = 1'b0,
    I_HOLD = 1'b1
  } istate_t;

  typedef enum logic {
    D_REQ  = 1'b0,
    D_DONE = 1'b1
  } dstate_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FREEZE = '0;
  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1
  };

  // True when an ID source that is actually read matches the EX destination.
  function automatic logic src_hit(input logic use_src,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/mem_port_tracker.sv
// Per-cache-port handshake tracker: captures a response that arrives while
// the other port still freezes the pipeline, so it is never re-requested.
module mem_port_tracker
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter type    state_t = istate_t,
  parameter state_t REQ_ST  = I_REQ,
  parameter state_t HOLD_ST = I_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  input  logic other_busy,
  output logic go,
  output logic latch,
  output logic sel_hold,
  output logic busy
);

  state_t state_q;
  state_t state_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= REQ_ST;
    else      state_q <= state_d;
  end

  // Next state. In the hold state this port is never busy, so the pipeline
  // stall reduces to the other port's busy term.
  always_comb begin
    state_d = state_q;
    if (state_q == REQ_ST) begin
      if (req && resp && other_busy) state_d = HOLD_ST;
    end else begin
      if (!other_busy) state_d = REQ_ST;
    end
  end

  // Outputs, all forced low while reset is asserted.
  always_comb begin
    go       = 1'b0;
    latch    = 1'b0;
    sel_hold = 1'b0;
    busy     = 1'b0;
    if (rst) begin
      go       = req && (state_q == REQ_ST);
      latch    = go && resp;
      busy     = go && !resp;
      sel_hold = (state_q == HOLD_ST);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the RV32I pipeline registers, with
// hazard-event performance counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  output logic             imem_read,
  output logic             imem_latch,
  output logic             imem_sel_hold,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             dmem_go,
  output logic             dmem_latch,
  output logic             dmem_sel_hold,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] loaduse_count,
  output logic [CNT_W-1:0] redirect_count
);

  logic        i_busy;
  logic        d_busy;
  logic        stall;
  logic        hazard;
  logic        redirect_fire;
  logic        loaduse_fire;
  stage_ctrl_t ctrl;

  mem_port_tracker #(
    .state_t(istate_t), .REQ_ST(I_REQ), .HOLD_ST(I_HOLD)
  ) u_iport (
    .clk(clk), .rst(rst), .req(1'b1), .resp(imem_resp), .other_busy(d_busy),
    .go(imem_read), .latch(imem_latch), .sel_hold(imem_sel_hold), .busy(i_busy)
  );

  mem_port_tracker #(
    .state_t(dstate_t), .REQ_ST(D_REQ), .HOLD_ST(D_DONE)
  ) u_dport (
    .clk(clk), .rst(rst), .req(dmem_req), .resp(dmem_resp), .other_busy(i_busy),
    .go(dmem_go), .latch(dmem_latch), .sel_hold(dmem_sel_hold), .busy(d_busy)
  );

  assign stall  = i_busy | d_busy;
  assign hazard = idex_mem_read && (idex_rd != '0) &&
                  (src_hit(ifid_use_rs1, ifid_rs1, idex_rd) ||
                   src_hit(ifid_use_rs2, ifid_rs2, idex_rd));

  // Stage control priority: freeze, redirect, load-use bubble, run.
  always_comb begin
    ctrl          = CTRL_FREEZE;
    redirect_fire = 1'b0;
    loaduse_fire  = 1'b0;
    if (!rst || stall) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_redirect) begin
      ctrl            = CTRL_RUN;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      redirect_fire   = 1'b1;
    end else if (hazard) begin
      ctrl            = CTRL_RUN;
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
      loaduse_fire    = 1'b1;
    end else begin
      ctrl = CTRL_RUN;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles   <= '0;
      loaduse_count  <= '0;
      redirect_count <= '0;
    end else begin
      if (stall)         stall_cycles   <= stall_cycles + CNT_W'(1);
      if (loaduse_fire)  loaduse_count  <= loaduse_count + CNT_W'(1);
      if (redirect_fire) redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a behavioural model pushes the
// expected outputs per cycle; each scenario task pops and compares.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             imem_resp = 1'b0;
  logic             imem_read, imem_latch, imem_sel_hold;
  logic             dmem_req = 1'b0;
  logic             dmem_resp = 1'b0;
  logic             dmem_go, dmem_latch, dmem_sel_hold;
  logic             idex_mem_read = 1'b0;
  logic [4:0]       idex_rd = '0;
  logic [4:0]       ifid_rs1 = '0;
  logic [4:0]       ifid_rs2 = '0;
  logic             ifid_use_rs1 = 1'b0;
  logic             ifid_use_rs2 = 1'b0;
  logic             ex_redirect = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [CNT_W-1:0] stall_cycles, loaduse_count, redirect_count;

  pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_resp(imem_resp), .imem_read(imem_read), .imem_latch(imem_latch),
    .imem_sel_hold(imem_sel_hold),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(dmem_go),
    .dmem_latch(dmem_latch), .dmem_sel_hold(dmem_sel_hold),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ex_redirect(ex_redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .stall_cycles(stall_cycles), .loaduse_count(loaduse_count), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir;
    logic       dq;
    logic       dr;
    logic       rx;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } stim_t;

  typedef struct packed {
    logic [12:0]      sig;
    logic [CNT_W-1:0] stall_c;
    logic [CNT_W-1:0] lu_c;
    logic [CNT_W-1:0] rd_c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Model state: port hold flags and counters.
  logic             m_ihold = 1'b0;
  logic             m_ddone = 1'b0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_lu = '0;
  logic [CNT_W-1:0] m_rd = '0;

  // Bit order: imem read/latch/sel, dmem go/latch/sel, pc,ifid en/flush,idex en/flush,exmem,memwb
  logic [12:0]  obs;
  logic [108:0] got;
  assign obs = {imem_read, imem_latch, imem_sel_hold, dmem_go, dmem_latch, dmem_sel_hold,
                pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
  assign got = {obs, stall_cycles, loaduse_count, redirect_count};

  function automatic stim_t st(input logic ir, input logic dq, input logic dr, input logic rx);
    stim_t s;
    s = '0;
    s.ir = ir; s.dq = dq; s.dr = dr; s.rx = rx;
    return s;
  endfunction

  function automatic stim_t hz(input stim_t b, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2);
    stim_t s;
    s = b;
    s.mr = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    return s;
  endfunction

  // Apply one cycle of stimulus, push the expected outputs, advance the model.
  task automatic drive(input stim_t s);
    logic ibusy, dgo, dbusy, stl, haz;
    logic [6:0] c;
    exp_t e;
    imem_resp = s.ir; dmem_req = s.dq; dmem_resp = s.dr; ex_redirect = s.rx;
    idex_mem_read = s.mr; idex_rd = s.rd; ifid_rs1 = s.rs1; ifid_rs2 = s.rs2;
    ifid_use_rs1 = s.u1; ifid_use_rs2 = s.u2;
    ibusy = !m_ihold && !s.ir;
    dgo   = s.dq && !m_ddone;
    dbusy = dgo && !s.dr;
    stl   = ibusy || dbusy;
    haz   = s.mr && (s.rd != 5'd0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (stl)       c = 7'b0000000;
    else if (s.rx) c = 7'b1111111;
    else if (haz)  c = 7'b0001111;
    else           c = 7'b1101011;
    e.sig = {!m_ihold, !m_ihold && s.ir, m_ihold, dgo, dgo && s.dr, m_ddone, c};
    e.stall_c = m_stall; e.lu_c = m_lu; e.rd_c = m_rd;
    exp_q.push_back(e);
    if (stl) m_stall = m_stall + 1;
    else if (s.rx) m_rd = m_rd + 1;
    else if (haz) m_lu = m_lu + 1;
    if (!m_ihold) m_ihold = s.ir && dbusy;
    else if (!stl) m_ihold = 1'b0;
    if (!m_ddone) m_ddone = dgo && s.dr && ibusy;
    else if (!stl) m_ddone = 1'b0;
  endtask

  task automatic model_reset();
    m_ihold = 1'b0; m_ddone = 1'b0; m_stall = '0; m_lu = '0; m_rd = '0;
  endtask

  task automatic test_reset();
    imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1; ex_redirect = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs, 13'd0);
    end
    total++;
    if ({stall_cycles, loaduse_count, redirect_count} !== '0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                      stall_cycles, loaduse_count, redirect_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_startup();
    stim_t seq[3];
    exp_t  e;
    seq[0] = st(0, 0, 0, 0); seq[1] = st(0, 0, 0, 0); seq[2] = st(1, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL startup cyc%0d: got sig=%b cnt=%0d want sig=%b cnt=%0d",
                        i + 1, obs, stall_cycles, e.sig, e.stall_c);
      end
      total++;
      if (imem_read !== 1'b1) begin
        bad++; $display("FAIL startup_read cyc%0d: got %b want 1", i + 1, imem_read);
      end
      if (i == 2) begin
        total++;
        if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, stall_cycles} !== {5'b11111, 32'd2}) begin
          bad++; $display("FAIL startup_advance: got en=%b stall_cycles=%0d want 11111 / 2",
                          {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, stall_cycles);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t seq[6];
    exp_t  e;
    logic [CNT_W-1:0] lu0;
    lu0 = m_lu;
    seq[0] = hz(st(1, 0, 0, 0), 1, 5'd5, 5'd5, 5'd0, 1, 0);
    seq[1] = st(1, 0, 0, 0);
    seq[2] = hz(st(1, 0, 0, 0), 1, 5'd0, 5'd0, 5'd0, 1, 1);
    seq[3] = hz(st(1, 0, 0, 0), 1, 5'd7, 5'd3, 5'd7, 1, 0);
    seq[4] = hz(st(1, 0, 0, 0), 1, 5'd7, 5'd3, 5'd7, 0, 1);
    seq[5] = st(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL load_use cyc%0d: got sig=%b lu=%0d want sig=%b lu=%0d",
                        i, obs, loaduse_count, e.sig, e.lu_c);
      end
      if (i == 0 || i == 2) begin
        total++;
        if ({pc_en, ifid_en, idex_flush} !== ((i == 0) ? 3'b001 : 3'b110)) begin
          bad++; $display("FAIL load_use_ctrl cyc%0d: got %b want %b", i,
                          {pc_en, ifid_en, idex_flush}, (i == 0) ? 3'b001 : 3'b110);
        end
      end
      if (i == 5) begin
        total++;
        if (loaduse_count !== lu0 + 2) begin
          bad++; $display("FAIL load_use_count: got %0d want %0d", loaduse_count, lu0 + 2);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dmem_hold();
    stim_t seq[6];
    exp_t  e;
    seq[0] = st(0, 1, 0, 0); seq[1] = st(0, 1, 1, 0); seq[2] = st(0, 1, 0, 0);
    seq[3] = st(0, 1, 0, 0); seq[4] = st(1, 1, 0, 0); seq[5] = st(1, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL dmem_hold cyc%0d: got sig=%b want sig=%b", i + 1, obs, e.sig);
      end
      if (i == 1) begin
        total++;
        if (dmem_latch !== 1'b1) begin
          bad++; $display("FAIL dmem_latch: got %b want 1", dmem_latch);
        end
      end
      if (i >= 2 && i <= 4) begin
        total++;
        if ({dmem_sel_hold, dmem_go, pc_en} !== {2'b10, (i == 4)}) begin
          bad++; $display("FAIL dmem_held cyc%0d: got sel/go/pc %b want %b", i + 1,
                          {dmem_sel_hold, dmem_go, pc_en}, {2'b10, (i == 4)});
        end
      end
      if (i == 5) begin
        total++;
        if ({dmem_sel_hold, dmem_go} !== 2'b01) begin
          bad++; $display("FAIL dmem_rearm: got sel/go %b want 01", {dmem_sel_hold, dmem_go});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_stall();
    stim_t seq[5];
    exp_t  e;
    logic [CNT_W-1:0] rd0;
    rd0 = m_rd;
    seq[0] = st(0, 0, 0, 1); seq[1] = st(0, 0, 0, 1); seq[2] = st(0, 0, 0, 1);
    seq[3] = st(1, 0, 0, 1); seq[4] = st(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL redirect_stall cyc%0d: got sig=%b rc=%0d want sig=%b rc=%0d",
                        i + 1, obs, redirect_count, e.sig, e.rd_c);
      end
      if (i <= 2) begin
        total++;
        if ({ifid_flush, idex_flush} !== 2'b00) begin
          bad++; $display("FAIL redirect_early cyc%0d: got flush %b want 00", i + 1,
                          {ifid_flush, idex_flush});
        end
      end
      if (i == 3) begin
        total++;
        if (obs[6:0] !== 7'b1111111) begin
          bad++; $display("FAIL redirect_apply: got ctrl %b want 1111111", obs[6:0]);
        end
      end
      if (i == 4) begin
        total++;
        if (redirect_count !== rd0 + 1) begin
          bad++; $display("FAIL redirect_count: got %0d want %0d", redirect_count, rd0 + 1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_vs_loaduse();
    exp_t e;
    logic [CNT_W-1:0] lu0, rd0;
    lu0 = m_lu; rd0 = m_rd;
    for (int i = 0; i < 2; i++) begin
      drive((i == 0) ? hz(st(1, 0, 0, 1), 1, 5'd9, 5'd9, 5'd9, 1, 1) : st(1, 0, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL redirect_vs_lu cyc%0d: got sig=%b want sig=%b", i, obs, e.sig);
      end
      if (i == 1) begin
        total++;
        if ({loaduse_count, redirect_count} !== {lu0, rd0 + 32'd1}) begin
          bad++; $display("FAIL redirect_wins: got lu=%0d rc=%0d want lu=%0d rc=%0d",
                          loaduse_count, redirect_count, lu0, rd0 + 1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 300; i++) begin
      s = st($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
             $urandom_range(1, 0) == 1, $urandom_range(7, 0) == 0);
      s = hz(s, $urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
             5'($urandom_range(3, 0)), $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
      drive(s);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL back_to_back cyc%0d: got sig=%b cnt=%0d/%0d/%0d want sig=%b cnt=%0d/%0d/%0d",
                        i, obs, stall_cycles, loaduse_count, redirect_count,
                        e.sig, e.stall_c, e.lu_c, e.rd_c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Get the D port into D_DONE while the I port is still missing.
    drive(st(1, 0, 0, 0));
    @(negedge clk); e = exp_q.pop_front();
    @(posedge clk); #1;
    drive(st(0, 1, 1, 0));
    @(negedge clk); e = exp_q.pop_front();
    @(posedge clk); #1;
    drive(st(0, 1, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (dmem_sel_hold !== 1'b1 || got !== e) begin
      bad++; $display("FAIL reset_mid_setup: got sig=%b want sig=%b", obs, e.sig);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_mid_outputs: got %b want %b", obs, 13'd0);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(st(0, 1, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL reset_mid_release: got sig=%b want sig=%b", obs, e.sig);
    end
    total++;
    if ({imem_read, dmem_go, imem_sel_hold, dmem_sel_hold, stall_cycles, loaduse_count, redirect_count}
        !== {4'b1100, 96'd0}) begin
      bad++; $display("FAIL reset_mid_state: got rd/go/selI/selD %b cnt=%0d/%0d/%0d want 1100 cnt=0/0/0",
                      {imem_read, dmem_go, imem_sel_hold, dmem_sel_hold},
                      stall_cycles, loaduse_count, redirect_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_load_use();
    test_dmem_hold();
    test_redirect_stall();
    test_redirect_vs_loaduse();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
